// File: rtl/sq_pkg.sv
// Shared definitions for the serial pattern source and the sequence detectors.
// Holds the state encoding and the default idle line level.
package sq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } sq_state_e;

  localparam logic IDLE_LVL_DEF = 1'b0;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned REP_W_DEF = 4;
  localparam int unsigned GAP_DEF   = 2;

endpackage

// File: rtl/sq_pattern_tx_if.sv
// Request/serial-output bundle of the pattern transmitter.
// The master side requests transfers; the slave side is the transmitter.
interface sq_pattern_tx_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [REP_W-1:0] repeat_cnt;
  logic             abort;
  logic             out_data;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_cnt, abort,
    input  out_data, busy, done
  );

  modport slave (
    input  start, pattern, repeat_cnt, abort,
    output out_data, busy, done
  );
endinterface

// File: rtl/sq_shift_reg.sv
// Parallel-load, MSB-first shift register holding the frame in flight.
// Load takes priority over shift.
module sq_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sq_pattern_tx.sv
// Serial pattern transmitter: sends a captured WIDTH-bit frame MSB-first,
// repeat_cnt+1 times, separated by GAP idle cycles.
module sq_pattern_tx
  import sq_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned REP_W    = REP_W_DEF,
  parameter int unsigned GAP      = GAP_DEF,
  parameter logic        IDLE_LVL = IDLE_LVL_DEF
) (
  input logic                clk,
  input logic                rst_n,
  sq_pattern_tx_if.slave     bus
);

  localparam int unsigned IW       = $clog2(WIDTH);
  localparam int unsigned GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int unsigned GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

  sq_state_e        state;
  logic [IW-1:0]    bit_idx;
  logic [REP_W-1:0] frames_left;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] sr_q;
  logic             out_q;
  logic             busy_q;
  logic             done_q;

  logic             load_c;
  logic             shift_c;
  logic [WIDTH-1:0] load_data_c;

  // Shift-register control: load on accept or on the start of a repeat frame.
  always_comb begin
    load_c      = 1'b0;
    shift_c     = 1'b0;
    load_data_c = pat_q;
    unique case (state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          load_c      = 1'b1;
          load_data_c = bus.pattern;
        end
      end
      ST_SEND: begin
        if (!bus.abort) begin
          if (bit_idx != '0) begin
            shift_c = 1'b1;
          end else if (frames_left != '0 && GAP == 0) begin
            load_c = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (!bus.abort && gap_cnt == '0) begin
          load_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  sq_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_c),
    .shift (shift_c),
    .din   (load_data_c),
    .q     (sr_q)
  );

  // Transfer FSM with registered out_data/busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_idx     <= '0;
      frames_left <= '0;
      gap_cnt     <= '0;
      pat_q       <= '0;
      out_q       <= IDLE_LVL;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          out_q  <= IDLE_LVL;
          busy_q <= 1'b0;
          if (bus.start && !bus.abort) begin
            pat_q       <= bus.pattern;
            frames_left <= bus.repeat_cnt;
            bit_idx     <= IW'(WIDTH - 1);
            out_q       <= bus.pattern[WIDTH-1];
            busy_q      <= 1'b1;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            out_q  <= IDLE_LVL;
            busy_q <= 1'b0;
          end else if (bit_idx != '0) begin
            bit_idx <= bit_idx - IW'(1);
            out_q   <= sr_q[WIDTH-2];
          end else if (frames_left == '0) begin
            state  <= ST_DONE;
            out_q  <= IDLE_LVL;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            frames_left <= frames_left - REP_W'(1);
            if (GAP > 0) begin
              state   <= ST_GAP;
              gap_cnt <= GW'(GAP_LOAD);
              out_q   <= IDLE_LVL;
            end else begin
              bit_idx <= IW'(WIDTH - 1);
              out_q   <= pat_q[WIDTH-1];
            end
          end
        end
        ST_GAP: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            out_q  <= IDLE_LVL;
            busy_q <= 1'b0;
          end else if (gap_cnt == '0) begin
            state   <= ST_SEND;
            bit_idx <= IW'(WIDTH - 1);
            out_q   <= pat_q[WIDTH-1];
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          out_q  <= IDLE_LVL;
          busy_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_data = out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_sq_pattern_tx.sv
// Directed bench for sq_pattern_tx: a GAP=2 instance driven from a vector table
// plus hand sequences, and a GAP=0 instance for back-to-back frames.
module tb_sq_pattern_tx;
  import sq_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned RW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sq_pattern_tx_if #(.WIDTH(W), .REP_W(RW)) b2 ();
  sq_pattern_tx_if #(.WIDTH(W), .REP_W(RW)) b0 ();

  sq_pattern_tx #(.WIDTH(W), .REP_W(RW), .GAP(2), .IDLE_LVL(1'b0)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  sq_pattern_tx #(.WIDTH(W), .REP_W(RW), .GAP(0), .IDLE_LVL(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  typedef struct {
    logic [W-1:0]  pat;
    logic [RW-1:0] rep;
    int            exp_busy;
    int            exp_done;
  } vec_t;

  vec_t vecs [5];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level at edge e for a GAP=2 transfer of busy length nb.
  function automatic logic exp_bit(input logic [W-1:0] pat, input int e, input int nb);
    int pos;
    if (e < 1 || e > nb) return 1'b0;
    pos = (e - 1) % (W + 2);
    if (pos < W) return pat[W-1-pos];
    return 1'b0;
  endfunction

  task automatic run_vec(input int idx, input logic [W-1:0] pat, input logic [RW-1:0] rep,
                         input int exp_busy, input int exp_done);
    int busy_cnt, done_cnt, done_edge, bad;
    busy_cnt = 0; done_cnt = 0; done_edge = 0; bad = 0;
    b2.pattern = pat; b2.repeat_cnt = rep; b2.start = 1'b1;
    for (int e = 1; e <= 300; e++) begin
      step();
      if (e == 1) begin
        b2.start = 1'b0; b2.pattern = ~pat; b2.repeat_cnt = '0;
      end
      if (b2.busy) busy_cnt++;
      if (b2.done) begin done_cnt++; done_edge = e; end
      if (b2.out_data !== exp_bit(pat, e, exp_busy)) bad++;
      if (done_edge != 0 && e >= done_edge + 2) break;
    end
    chk($sformatf("vec%0d busy_cycles", idx), busy_cnt, exp_busy);
    chk($sformatf("vec%0d done_edge", idx), done_edge, exp_done);
    chk($sformatf("vec%0d done_pulses", idx), done_cnt, 1);
    chk($sformatf("vec%0d stream_errors", idx), bad, 0);
  endtask

  initial begin
    int busy_cnt, done_cnt, done_edge, bad;
    logic ev;

    vecs[0] = '{pat: 8'h5B, rep: 4'd0,  exp_busy: 8,   exp_done: 9};
    vecs[1] = '{pat: 8'hA5, rep: 4'd1,  exp_busy: 18,  exp_done: 19};
    vecs[2] = '{pat: 8'hFF, rep: 4'd0,  exp_busy: 8,   exp_done: 9};
    vecs[3] = '{pat: 8'h01, rep: 4'd2,  exp_busy: 28,  exp_done: 29};
    vecs[4] = '{pat: 8'h80, rep: 4'd15, exp_busy: 158, exp_done: 159};

    b2.start = 1'b0; b2.pattern = '0; b2.repeat_cnt = '0; b2.abort = 1'b0;
    b0.start = 1'b0; b0.pattern = '0; b0.repeat_cnt = '0; b0.abort = 1'b0;

    // Reset state
    #7;
    chk("reset out_data", int'(b2.out_data), 0);
    chk("reset busy", int'(b2.busy), 0);
    chk("reset done", int'(b2.done), 0);
    #6 rst_n = 1'b1;
    step();
    chk("post-reset busy", int'(b2.busy), 0);
    chk("post-reset gap0 busy", int'(b0.busy), 0);

    for (int i = 0; i < 5; i++)
      run_vec(i, vecs[i].pat, vecs[i].rep, vecs[i].exp_busy, vecs[i].exp_done);

    // GAP=0 build: three back-to-back F0 frames
    busy_cnt = 0; done_edge = 0; bad = 0;
    b0.pattern = 8'hF0; b0.repeat_cnt = 4'd2; b0.start = 1'b1;
    for (int e = 1; e <= 27; e++) begin
      step();
      if (e == 1) b0.start = 1'b0;
      ev = (e <= 24) ? (((e - 1) % 8) < 4) : 1'b0;
      if (b0.busy) busy_cnt++;
      if (b0.done && done_edge == 0) done_edge = e;
      if (b0.out_data !== ev) bad++;
    end
    chk("gap0 busy_cycles", busy_cnt, 24);
    chk("gap0 done_edge", done_edge, 25);
    chk("gap0 stream_errors", bad, 0);

    // Abort at edge 4, restart at edge 6
    b2.pattern = 8'h5B; b2.repeat_cnt = '0; b2.start = 1'b1;
    step(); b2.start = 1'b0;
    step(); step();
    b2.abort = 1'b1;
    step();
    b2.abort = 1'b0;
    chk("abort busy", int'(b2.busy), 0);
    chk("abort out_data", int'(b2.out_data), 0);
    step();
    chk("abort no done", int'(b2.done), 0);
    b2.pattern = 8'hC3; b2.start = 1'b1;
    step(); b2.start = 1'b0;
    chk("restart busy", int'(b2.busy), 1);
    chk("restart first bit", int'(b2.out_data), 1);
    done_edge = 0;
    for (int e = 7; e <= 20; e++) begin
      step();
      if (b2.done && done_edge == 0) done_edge = e;
    end
    chk("restart done_edge", done_edge, 14);

    // Start + abort together in IDLE: nothing accepted
    b2.pattern = 8'hFF; b2.start = 1'b1; b2.abort = 1'b1;
    step();
    b2.start = 1'b0; b2.abort = 1'b0;
    chk("start+abort busy", int'(b2.busy), 0);
    step();
    chk("start+abort busy later", int'(b2.busy), 0);

    // Start re-pulsed at edge 3 with 8'h00 is ignored
    bad = 0; done_edge = 0;
    b2.pattern = 8'h5B; b2.repeat_cnt = '0; b2.start = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      step();
      b2.start = (e == 2);
      if (e == 2) b2.pattern = 8'h00;
      if (b2.done && done_edge == 0) done_edge = e;
      if (b2.out_data !== exp_bit(8'h5B, e, 8)) bad++;
    end
    chk("restart-ignored stream_errors", bad, 0);
    chk("restart-ignored done_edge", done_edge, 9);

    // Start in DONE is ignored; abort in DONE leaves the done pulse intact
    b2.pattern = 8'h81; b2.start = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e == 1) b2.start = 1'b0;
    end
    chk("done pulse", int'(b2.done), 1);
    b2.start = 1'b1; b2.abort = 1'b1;
    step();
    b2.start = 1'b0; b2.abort = 1'b0;
    chk("start in done busy", int'(b2.busy), 0);
    step();
    chk("start in done busy later", int'(b2.busy), 0);

    // Asynchronous reset between edges 5 and 6
    b2.pattern = 8'h5B; b2.start = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      if (e == 1) b2.start = 1'b0;
    end
    chk("pre-reset busy", int'(b2.busy), 1);
    chk("pre-reset out_data", int'(b2.out_data), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_data", int'(b2.out_data), 0);
    chk("async reset busy", int'(b2.busy), 0);
    #1 rst_n = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int e = 0; e < 12; e++) begin
      step();
      if (b2.busy) busy_cnt++;
      if (b2.done) done_cnt++;
    end
    chk("after reset busy_cycles", busy_cnt, 0);
    chk("after reset done_pulses", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
